// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   uart_rx_state_t : receiver FSM states
//   PARITY_*        : encodings of the PARITY_MODE parameter
//   uart_params_ok  : legality check applied to the receiver parameters at
//                     elaboration time
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5,
        CLEANUP    = 3'd6
    } uart_rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // A bit time below 8 clocks leaves no room for the synchroniser delay
    // plus a centred 3-sample vote.
    function automatic bit uart_params_ok(input int clks_per_bit,
                                          input int data_bits,
                                          input int parity_mode,
                                          input int stop_bits);
        return (clks_per_bit >= 8) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity_mode >= PARITY_NONE) && (parity_mode <= PARITY_EVEN) &&
               (stop_bits >= 1) && (stop_bits <= 2);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial-in / frame-out bundle of the UART receiver.
//   i_RX_Serial  : serial line, idles high
//   o_RX_DV      : one-cycle pulse per completed frame
//   o_RX_Byte    : received data word, held until the next o_RX_DV
//   o_Parity_Err : parity mismatch on the last frame
//   o_Frame_Err  : a stop bit was sampled low on the last frame
//   o_Break      : the last frame was a line break
// master = receiver side, slave = line driver / frame consumer side.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_RX_Serial;
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;

    modport master (
        input  i_RX_Serial,
        output o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break
    );

    modport slave (
        output i_RX_Serial,
        input  o_RX_DV, o_RX_Byte, o_Parity_Err, o_Frame_Err, o_Break
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver: a 2-flop synchroniser followed
// by a 3-tap history used for a 2-of-3 majority vote.
//   i_Clock, i_Rst_n : clock, asynchronous active-low reset
//   i_RX_Serial      : raw asynchronous serial line
//   o_Sync           : synchronised line level
//   o_Vote           : majority of the current and two previous synced samples
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_RX_Serial,
    output logic o_Sync,
    output logic o_Vote
);

    logic       sync_p0;
    logic       sync_p1;
    logic [1:0] hist_p2;

    // Reset to the idle (high) level so leaving reset never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            hist_p2 <= 2'b11;
        end else begin
            sync_p0 <= i_RX_Serial;
            sync_p1 <= sync_p0;
            hist_p2 <= {hist_p2[0], sync_p1};
        end
    end

    assign o_Sync = sync_p1;
    // A single-clock glitch can corrupt only one of the three votes.
    assign o_Vote = (sync_p1 & hist_p2[0]) | (sync_p1 & hist_p2[1]) |
                    (hist_p2[0] & hist_p2[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, none/odd/even parity,
// 1 or 2 stop bits, with parity, framing and line-break detection.
//   i_Clock  : single clock, rising edge
//   i_Rst_n  : asynchronous active-low reset
//   rx_bus   : uart_rx_cfg_if.master (serial line in, frame results out)
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_Clock,
    input  logic          i_Rst_n,
    uart_rx_cfg_if.master rx_bus
);

    if (!uart_params_ok(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS)) begin : g_param_err
        $error("uart_rx_cfg: illegal CLKS_PER_BIT/DATA_BITS/PARITY_MODE/STOP_BITS");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    logic rx_sync;
    logic rx_vote;

    uart_rx_sync u_sync (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_RX_Serial (rx_bus.i_RX_Serial),
        .o_Sync      (rx_sync),
        .o_Vote      (rx_vote)
    );

    uart_rx_state_t       state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;      // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 done;              // last stop bit decided this cycle

    logic                 dv_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 perr_o_q;
    logic                 ferr_o_q;
    logic                 brk_o_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        brk_d     = brk_q;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
                brk_d  = 1'b0;
                if (!rx_sync) state_d = START;
            end

            // Confirm the start bit at its centre; a high vote is a false start.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_vote ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_vote;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_vote;
                    if (PARITY_MODE == PARITY_ODD) perr_d = ~(^data_q ^ rx_vote);
                    else                           perr_d = ^data_q ^ rx_vote;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_vote) ferr_d = 1'b1;
                    // Break is judged on the first stop bit only: an all-zero frame.
                    if (idx_q == '0) begin
                        brk_d = (data_q == '0) &&
                                ((PARITY_MODE == PARITY_NONE) || !par_bit_q) &&
                                !rx_vote;
                    end
                    if (idx_q == STOP_LAST) begin
                        done    = 1'b1;
                        idx_d   = '0;
                        state_d = brk_d ? BREAK_WAIT : CLEANUP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Hold off until the line is released so a long break yields one frame.
            BREAK_WAIT: begin
                if (rx_sync) state_d = IDLE;
            end

            CLEANUP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
            dv_q     <= 1'b0;
            byte_q   <= '0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            brk_o_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            dv_q    <= done;
            if (done) begin
                byte_q   <= data_q;
                perr_o_q <= perr_d;
                ferr_o_q <= ferr_d;
                brk_o_q  <= brk_d;
            end
        end
    end

    // Shift data needs no reset: every bit is rewritten before it is published.
    always_ff @(posedge i_Clock) begin
        data_q    <= data_d;
        par_bit_q <= par_bit_d;
    end

    assign rx_bus.o_RX_DV      = dv_q;
    assign rx_bus.o_RX_Byte    = byte_q;
    assign rx_bus.o_Parity_Err = perr_o_q;
    assign rx_bus.o_Frame_Err  = ferr_o_q;
    assign rx_bus.o_Break      = brk_o_q;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 CLKS_PER_BIT, 217, clocks per bit = f(i_Clock)/baud; legal values are 8 or greater.
REQ-002 DATA_BITS, 8, data bits per frame; legal range is 5..9.
REQ-003 PARITY_MODE, 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 STOP_BITS, 1, stop bits per frame; legal values are 1 and 2.
REQ-005 i_Clock  input  1  single clock; all logic is on its rising edge.
REQ-006 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_RX_Serial  input  1  asynchronous serial line; idle level is high.
REQ-008 o_RX_DV  output  1  one-cycle pulse when a frame completes.
REQ-009 o_RX_Byte  output  DATA_BITS  received data, LSB first on the line; valid with o_RX_DV and held until the next o_RX_DV.
REQ-010 o_Parity_Err  output  1  parity mismatch on the last frame; valid with o_RX_DV and held until the next o_RX_DV.
REQ-011 o_Frame_Err  output  1  a stop bit was sampled low on the last frame; valid with o_RX_DV and held until the next o_RX_DV.
REQ-012 o_Break  output  1  a break was detected on the last frame; valid with o_RX_DV and held until the next o_RX_DV.

Function
REQ-013 i_RX_Serial SHALL pass through a 2-flop synchroniser before any use.
REQ-014 Each bit decision SHALL be the 2-of-3 majority of synced samples taken on the decision cycle and the two cycles before it.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK_WAIT and CLEANUP.
REQ-016 IDLE: a synced low SHALL move the FSM to START with the bit counter at 0.
REQ-017 START: the decision SHALL occur at counter = (CLKS_PER_BIT-1)/2; low -> DATA with counter cleared, high -> IDLE (false start, no o_RX_DV).
REQ-018 DATA/PARITY/STOP: each decision SHALL occur when the counter reaches CLKS_PER_BIT-1, after which the counter clears.
REQ-019 DATA SHALL shift the decided bit into position bit_index, then go to PARITY if PARITY_MODE != 0, else to STOP.
REQ-020 PARITY: the error SHALL be set when XOR(data, parity bit) is 0 in odd mode or 1 in even mode.
REQ-021 STOP SHALL sample STOP_BITS stop bits; any low stop bit SHALL set the frame error.
REQ-022 o_RX_DV SHALL pulse on the cycle after the last stop-bit decision, updating o_RX_Byte, o_Parity_Err, o_Frame_Err and o_Break on that same edge.
REQ-023 After the last stop-bit decision the FSM SHALL go to CLEANUP for one cycle, then IDLE, so a back-to-back start bit is detected within half a bit time.
REQ-024 Break SHALL be declared when all data bits, the parity bit (if any) and the first stop bit are 0; o_Frame_Err=1 and o_Break=1 with o_RX_DV.
REQ-025 On break the FSM SHALL enter BREAK_WAIT and stay there until the synced line is high, then return to IDLE.
REQ-026 Counter width SHALL be $clog2(CLKS_PER_BIT); bit_index width SHALL be $clog2(DATA_BITS); neither SHALL ever wrap within a frame.
REQ-027 A line glitch shorter than 2 clocks SHALL NOT change any bit decision.

Reset
REQ-028 When i_Rst_n=0: FSM = IDLE, counters = 0, synchroniser and majority flops = 1, o_RX_DV=0, o_RX_Byte=0, and all error flags = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no o_RX_DV pulse; after deassertion, reception SHALL resume only on a fresh falling edge.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, the PARITY_NONE/ODD/EVEN constants and a parameter-legality check function.
REQ-031 Sub-module uart_rx_sync SHALL hold the 2-flop synchroniser plus the 3-tap majority shift register and output the synced bit and the vote.
REQ-032 Illegal parameter values SHALL cause an elaboration-time error.

Verification (CLKS_PER_BIT=16)
REQ-033 8N1, send 0xA5 -> one o_RX_DV pulse, o_RX_Byte=0xA5, all error flags 0.
REQ-034 7E1, send 0x41 with the parity bit forced to 1 -> o_RX_Byte=0x41, o_Parity_Err=1, o_Frame_Err=0.
REQ-035 8N2, send 0x3C with the second stop bit low -> o_Frame_Err=1, o_Break=0.
REQ-036 8N1, hold the line low for 30 bit times -> o_Break=1, o_Frame_Err=1, o_RX_Byte=0x00, and no further o_RX_DV until the line returns high followed by a new frame.
REQ-037 8N1, 1-clock low glitch in idle plus a 1-clock inverted glitch at a data-bit centre of frame 0x5A -> no false frame, o_RX_Byte=0x5A.
REQ-038 8N1, reset asserted during bit 4 of 0xFF, then frames 0x12 and 0x34 sent back-to-back -> no pulse for 0xFF, two pulses 0x12 then 0x34.
